// File: rtl/batalla_pkg.sv
// Types shared by the naval-battle turn controller and the VGA colour path.
package batalla_pkg;

    localparam int BOARD_N = 5;

    typedef enum logic [2:0] {
        AGUA    = 3'd0,
        BARCO   = 3'd1,
        FALLO   = 3'd2,
        IMPACTO = 3'd3
    } celda_t;

    typedef enum logic [2:0] {
        SETUP     = 3'd0,
        TURN_JUG  = 3'd1,
        APPLY_JUG = 3'd2,
        TURN_PC   = 3'd3,
        APPLY_PC  = 3'd4,
        OVER      = 3'd5
    } estado_t;

endpackage

// File: rtl/turn_timer.sv
// Player-turn watchdog: counts enabled cycles and flags the last allowed cycle.
module turn_timer #(
    parameter int TIMEOUT_CYCLES = 750_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [29:0] LIMIT = 30'(TIMEOUT_CYCLES - 1);

    logic [29:0] cnt;

    // Holds at LIMIT so a stalled turn keeps reporting expiry rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 30'd1;
        end
    end

    assign expired = en && (cnt == LIMIT);

endmodule

// File: rtl/control_turnos.sv
// Turn sequencer for the 5x5 naval-battle game: owns both boards, applies placements
// and shots, and alternates player/PC turns with a timeout on the player side.
module control_turnos #(
    parameter int TIMEOUT_CYCLES = 750_000_000,
    parameter int BOARD_N        = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       place_valid,
    input  logic       place_board,
    input  logic [2:0] place_row,
    input  logic [2:0] place_col,
    input  logic       jug_valid,
    input  logic [2:0] jug_row,
    input  logic [2:0] jug_col,
    output logic       jug_ready,
    input  logic       pc_valid,
    input  logic [2:0] pc_row,
    input  logic [2:0] pc_col,
    output logic       pc_ready,
    output logic [2:0] jugador_tablero [BOARD_N-1:0][BOARD_N-1:0],
    output logic [2:0] PC_tablero      [BOARD_N-1:0][BOARD_N-1:0],
    output logic       turno,
    output logic       result_valid,
    output logic       result_hit,
    output logic       timeout,
    output logic       game_over,
    output logic       winner
);
    import batalla_pkg::*;

    estado_t    state, state_nx;
    logic [4:0] barcos_jug, barcos_pc;
    logic [2:0] shot_row, shot_col;
    logic       hs_jug, hs_pc, expired, place_en;
    logic       tgt_pc, coord_ok, shot_ok, shot_hit, apply_en, clear_all;
    logic [2:0] tgt_cell;
    logic [4:0] tgt_cnt;
    logic       result_valid_nx, result_hit_nx, timeout_nx, winner_nx;

    assign jug_ready = (state == TURN_JUG);
    assign pc_ready  = (state == TURN_PC);
    assign turno     = (state == TURN_PC) || (state == APPLY_PC);
    assign game_over = (state == OVER);
    assign hs_jug    = jug_valid && jug_ready;
    assign hs_pc     = pc_valid && pc_ready;
    assign place_en  = (state == SETUP) && place_valid &&
                       (place_row < 3'(BOARD_N)) && (place_col < 3'(BOARD_N));

    turn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state != TURN_JUG),
        .en      (state == TURN_JUG),
        .expired (expired)
    );

    always_comb begin
        state_nx        = state;
        tgt_pc          = (state == APPLY_JUG);
        coord_ok        = (shot_row < 3'(BOARD_N)) && (shot_col < 3'(BOARD_N));
        tgt_cell        = AGUA;
        tgt_cnt         = tgt_pc ? barcos_pc : barcos_jug;
        apply_en        = 1'b0;
        clear_all       = 1'b0;
        result_valid_nx = 1'b0;
        result_hit_nx   = 1'b0;
        timeout_nx      = 1'b0;
        winner_nx       = winner;
        if (coord_ok)
            tgt_cell = tgt_pc ? PC_tablero[shot_row][shot_col] : jugador_tablero[shot_row][shot_col];
        shot_ok  = coord_ok && ((tgt_cell == AGUA) || (tgt_cell == BARCO));
        shot_hit = (tgt_cell == BARCO);

        case (state)
            SETUP: begin
                // Judged on the counters before any placement landing this same edge.
                if (start && (barcos_jug != 5'd0) && (barcos_pc != 5'd0))
                    state_nx = TURN_JUG;
            end
            TURN_JUG: begin
                if (hs_jug) begin
                    state_nx = APPLY_JUG;
                end else if (expired) begin
                    state_nx   = TURN_PC;
                    timeout_nx = 1'b1;
                end
            end
            TURN_PC: begin
                if (hs_pc) state_nx = APPLY_PC;
            end
            APPLY_JUG, APPLY_PC: begin
                if (!shot_ok) begin
                    state_nx = tgt_pc ? TURN_JUG : TURN_PC;
                end else begin
                    apply_en        = 1'b1;
                    result_valid_nx = 1'b1;
                    result_hit_nx   = shot_hit;
                    if (shot_hit && (tgt_cnt == 5'd1)) begin
                        state_nx  = OVER;
                        winner_nx = ~tgt_pc;
                    end else begin
                        state_nx = tgt_pc ? TURN_PC : TURN_JUG;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    clear_all = 1'b1;
                    winner_nx = 1'b0;
                    state_nx  = SETUP;
                end
            end
            default: state_nx = SETUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETUP;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_valid <= 1'b0;
            result_hit   <= 1'b0;
            timeout      <= 1'b0;
            winner       <= 1'b0;
            shot_row     <= 3'd0;
            shot_col     <= 3'd0;
        end else begin
            result_valid <= result_valid_nx;
            result_hit   <= result_hit_nx;
            timeout      <= timeout_nx;
            winner       <= winner_nx;
            if (hs_jug) begin
                shot_row <= jug_row;
                shot_col <= jug_col;
            end else if (hs_pc) begin
                shot_row <= pc_row;
                shot_col <= pc_col;
            end
        end
    end

    // Boards and ship counters; placement and shot application never overlap (different states).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jugador_tablero <= '{default: AGUA};
            PC_tablero      <= '{default: AGUA};
            barcos_jug      <= 5'd0;
            barcos_pc       <= 5'd0;
        end else if (clear_all) begin
            jugador_tablero <= '{default: AGUA};
            PC_tablero      <= '{default: AGUA};
            barcos_jug      <= 5'd0;
            barcos_pc       <= 5'd0;
        end else if (place_en) begin
            if (place_board) begin
                if (PC_tablero[place_row][place_col] == AGUA) begin
                    PC_tablero[place_row][place_col] <= BARCO;
                    barcos_pc <= barcos_pc + 5'd1;
                end
            end else begin
                if (jugador_tablero[place_row][place_col] == AGUA) begin
                    jugador_tablero[place_row][place_col] <= BARCO;
                    barcos_jug <= barcos_jug + 5'd1;
                end
            end
        end else if (apply_en) begin
            if (tgt_pc) begin
                PC_tablero[shot_row][shot_col] <= shot_hit ? IMPACTO : FALLO;
                if (shot_hit) barcos_pc <= barcos_pc - 5'd1;
            end else begin
                jugador_tablero[shot_row][shot_col] <= shot_hit ? IMPACTO : FALLO;
                if (shot_hit) barcos_jug <= barcos_jug - 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_control_turnos.sv
// Bench for control_turnos: expected shot outcomes queued at issue time and matched
// against result_valid/result_hit, plus per-scenario board and status checks.
`timescale 1ns/1ps
module tb_control_turnos;

    localparam logic [2:0] C_AGUA    = 3'd0;
    localparam logic [2:0] C_BARCO   = 3'd1;
    localparam logic [2:0] C_FALLO   = 3'd2;
    localparam logic [2:0] C_IMPACTO = 3'd3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       place_valid = 1'b0;
    logic       place_board = 1'b0;
    logic [2:0] place_row = 3'd0;
    logic [2:0] place_col = 3'd0;
    logic       jug_valid = 1'b0;
    logic [2:0] jug_row = 3'd0;
    logic [2:0] jug_col = 3'd0;
    logic       jug_ready;
    logic       pc_valid = 1'b0;
    logic [2:0] pc_row = 3'd0;
    logic [2:0] pc_col = 3'd0;
    logic       pc_ready;
    logic [2:0] jug_tab [4:0][4:0];
    logic [2:0] pc_tab  [4:0][4:0];
    logic       turno, result_valid, result_hit, timeout, game_over, winner;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    control_turnos #(.TIMEOUT_CYCLES(8), .BOARD_N(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .place_valid     (place_valid),
        .place_board     (place_board),
        .place_row       (place_row),
        .place_col       (place_col),
        .jug_valid       (jug_valid),
        .jug_row         (jug_row),
        .jug_col         (jug_col),
        .jug_ready       (jug_ready),
        .pc_valid        (pc_valid),
        .pc_row          (pc_row),
        .pc_col          (pc_col),
        .pc_ready        (pc_ready),
        .jugador_tablero (jug_tab),
        .PC_tablero      (pc_tab),
        .turno           (turno),
        .result_valid    (result_valid),
        .result_hit      (result_hit),
        .timeout         (timeout),
        .game_over       (game_over),
        .winner          (winner)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every result pulse must match the oldest issued shot.
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: result_valid=1 hit=%0b, no shot pending", result_hit);
            end else if (result_hit !== exp_q[0]) begin
                errors++;
                $display("FAIL result_hit: got %0b expected %0b", result_hit, exp_q[0]);
                void'(exp_q.pop_front());
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input bit brd, input logic [2:0] r, input logic [2:0] c);
        place_valid = 1'b1;
        place_board = brd;
        place_row   = r;
        place_col   = c;
        tick();
        place_valid = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for the side's ready, then presents one shot; returns just after the handshake edge.
    task automatic drive_shot(input bit pc, input logic [2:0] r, input logic [2:0] c);
        int n = 0;
        while (((pc ? pc_ready : jug_ready) !== 1'b1) && (n < 20)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL ready_wait: ready never rose for side %0b, got 0 required 1", pc);
        end
        if (pc) begin
            pc_valid = 1'b1; pc_row = r; pc_col = c;
        end else begin
            jug_valid = 1'b1; jug_row = r; jug_col = c;
        end
        tick();
        pc_valid  = 1'b0;
        jug_valid = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({turno, jug_ready, pc_ready, result_valid, result_hit, timeout, game_over, winner} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {turno, jug_ready, pc_ready, result_valid, result_hit, timeout, game_over, winner});
        end
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (jug_tab[r][c] !== C_AGUA || pc_tab[r][c] !== C_AGUA) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_boards: %0d non-AGUA cells, required 0", bad);
        end
    endtask

    task automatic test_setup();
        int bad = 0;
        place(1'b0, 3'd0, 3'd0);
        place(1'b1, 3'd5, 3'd0);
        press_start();
        checks++;
        if (jug_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_empty_pc: jug_ready=%0b required 0", jug_ready);
        end
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (pc_tab[r][c] !== C_AGUA) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL place_oob: %0d PC cells written, required 0", bad);
        end
        checks++;
        if (jug_tab[0][0] !== C_BARCO) begin
            errors++;
            $display("FAIL place_jug: cell=%0d required %0d", jug_tab[0][0], C_BARCO);
        end
        // start together with the first PC ship: judged on the old (empty) counter
        place_valid = 1'b1; place_board = 1'b1; place_row = 3'd2; place_col = 3'd3; start = 1'b1;
        tick();
        place_valid = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (jug_ready !== 1'b0 || pc_tab[2][3] !== C_BARCO) begin
            errors++;
            $display("FAIL start_with_place: jug_ready=%0b cell=%0d required 0 and %0d",
                     jug_ready, pc_tab[2][3], C_BARCO);
        end
        press_start();
        checks++;
        if ({turno, jug_ready} !== 2'b01) begin
            errors++;
            $display("FAIL start_enter: turno/jug_ready=%b required 01", {turno, jug_ready});
        end
    endtask

    task automatic test_hit_win();
        int bad = 0;
        exp_q.push_back(1'b1);
        drive_shot(1'b0, 3'd2, 3'd3);
        checks++;
        if (jug_ready !== 1'b0 || pc_tab[2][3] !== C_BARCO) begin
            errors++;
            $display("FAIL apply_latency: jug_ready=%0b cell=%0d required 0 and %0d",
                     jug_ready, pc_tab[2][3], C_BARCO);
        end
        tick();
        checks++;
        if (pc_tab[2][3] !== C_IMPACTO || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL hit_write: cell=%0d result_valid=%0b required %0d and 1",
                     pc_tab[2][3], result_valid, C_IMPACTO);
        end
        checks++;
        if ({game_over, winner} !== 2'b10) begin
            errors++;
            $display("FAIL win_player: game_over/winner=%b required 10", {game_over, winner});
        end
        tick();
        checks++;
        if (result_valid !== 1'b0 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL result_pulse: result_valid=%0b game_over=%0b required 0 and 1",
                     result_valid, game_over);
        end
        press_start();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (jug_tab[r][c] !== C_AGUA || pc_tab[r][c] !== C_AGUA) bad++;
        checks++;
        if (bad !== 0 || {game_over, winner, jug_ready} !== 3'b000) begin
            errors++;
            $display("FAIL restart_clear: %0d dirty cells, go/win/ready=%b required 0 and 000",
                     bad, {game_over, winner, jug_ready});
        end
    endtask

    task automatic test_miss_and_reshoot();
        place(1'b0, 3'd0, 3'd0);
        place(1'b0, 3'd4, 3'd4);
        place(1'b1, 3'd2, 3'd3);
        place(1'b1, 3'd3, 3'd3);
        press_start();
        exp_q.push_back(1'b0);
        drive_shot(1'b0, 3'd1, 3'd1);
        tick();
        checks++;
        if (pc_tab[1][1] !== C_FALLO || {result_valid, turno, pc_ready} !== 3'b111) begin
            errors++;
            $display("FAIL jug_miss: cell=%0d valid/turno/pc_ready=%b required %0d and 111",
                     pc_tab[1][1], {result_valid, turno, pc_ready}, C_FALLO);
        end
        exp_q.push_back(1'b0);
        drive_shot(1'b1, 3'd1, 3'd1);
        tick();
        checks++;
        if (jug_tab[1][1] !== C_FALLO || {result_valid, turno} !== 2'b10) begin
            errors++;
            $display("FAIL pc_miss: cell=%0d valid/turno=%b required %0d and 10",
                     jug_tab[1][1], {result_valid, turno}, C_FALLO);
        end
        drive_shot(1'b0, 3'd1, 3'd1);
        tick();
        checks++;
        if ({result_valid, turno, jug_ready} !== 3'b001) begin
            errors++;
            $display("FAIL reshoot_repeat: valid/turno/jug_ready=%b required 001",
                     {result_valid, turno, jug_ready});
        end
        drive_shot(1'b0, 3'd5, 3'd0);
        tick();
        checks++;
        if ({result_valid, turno, jug_ready} !== 3'b001) begin
            errors++;
            $display("FAIL shot_oob: valid/turno/jug_ready=%b required 001",
                     {result_valid, turno, jug_ready});
        end
        exp_q.push_back(1'b1);
        drive_shot(1'b0, 3'd3, 3'd3);
        tick();
        checks++;
        if (pc_tab[3][3] !== C_IMPACTO || {game_over, turno} !== 2'b01) begin
            errors++;
            $display("FAIL hit_continue: cell=%0d game_over/turno=%b required %0d and 01",
                     pc_tab[3][3], {game_over, turno}, C_IMPACTO);
        end
        exp_q.push_back(1'b1);
        drive_shot(1'b1, 3'd0, 3'd0);
        tick();
        checks++;
        if (jug_tab[0][0] !== C_IMPACTO || {game_over, turno} !== 2'b00) begin
            errors++;
            $display("FAIL pc_hit: cell=%0d game_over/turno=%b required %0d and 00",
                     jug_tab[0][0], {game_over, turno}, C_IMPACTO);
        end
    endtask

    // Entered right after the edge that put the FSM in TURN_JUG.
    task automatic test_timeout();
        int n = 0;
        while (timeout !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 8 || turno !== 1'b1) begin
            errors++;
            $display("FAIL timeout_cycles: pulse after %0d cycles turno=%0b required 8 and 1", n, turno);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: timeout=%0b required 0", timeout);
        end
        exp_q.push_back(1'b0);
        drive_shot(1'b1, 3'd4, 3'd0);
        tick();
        repeat (7) tick();
        exp_q.push_back(1'b0);
        jug_valid = 1'b1; jug_row = 3'd0; jug_col = 3'd4;
        tick();
        jug_valid = 1'b0;
        checks++;
        if (timeout !== 1'b0 || jug_ready !== 1'b0) begin
            errors++;
            $display("FAIL late_shot: timeout=%0b jug_ready=%0b required 0 and 0", timeout, jug_ready);
        end
        tick();
        checks++;
        if (pc_tab[0][4] !== C_FALLO || {result_valid, timeout, turno} !== 3'b101) begin
            errors++;
            $display("FAIL late_shot_apply: cell=%0d valid/timeout/turno=%b required %0d and 101",
                     pc_tab[0][4], {result_valid, timeout, turno}, C_FALLO);
        end
    endtask

    task automatic test_reset_apply();
        int bad = 0;
        drive_shot(1'b1, 3'd4, 3'd4);
        rst_n = 1'b0;
        #1;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                if (jug_tab[r][c] !== C_AGUA || pc_tab[r][c] !== C_AGUA) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_apply_boards: %0d non-AGUA cells, required 0", bad);
        end
        checks++;
        if ({turno, jug_ready, pc_ready, result_valid, result_hit, timeout, game_over, winner} !== 8'h00) begin
            errors++;
            $display("FAIL reset_apply_outputs: got %b required 00000000",
                     {turno, jug_ready, pc_ready, result_valid, result_hit, timeout, game_over, winner});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({result_valid, jug_ready, pc_ready, jug_tab[4][4]} !== {3'b000, C_AGUA}) begin
            errors++;
            $display("FAIL reset_release: valid/jr/pr=%b cell=%0d required 000 and %0d",
                     {result_valid, jug_ready, pc_ready}, jug_tab[4][4], C_AGUA);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_setup();
        test_hit_win();
        test_miss_and_reshoot();
        test_timeout();
        test_reset_apply();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL pending_results: %0d shots without a result, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
